// File: rtl/key_pkg.sv
// Shared key indices and command sizing for the key command arbiter.
package key_pkg;

    localparam int N_KEYS = 6;
    localparam int CMD_W  = 3;

    localparam int KEY_UP      = 0;
    localparam int KEY_DOWN    = 1;
    localparam int KEY_LEFT    = 2;
    localparam int KEY_RIGHT   = 3;
    localparam int KEY_UNDO    = 4;
    localparam int KEY_RESTART = 5;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through FIFO with flush.
module cmd_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // Head reads as zero while empty so the code output has a defined idle value.
    assign data_o  = empty_o ? '0 : mem_q[rd_q];
    assign count_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i && !flush_i) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/key_cmd_arbiter.sv
// Latches key press pulses and serialises them round-robin
// into an ordered command queue with valid/ready output.
module key_cmd_arbiter
    import key_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [N_KEYS-1:0] key_en,
    input  logic              flush,
    output logic              cmd_valid,
    output logic [CMD_W-1:0]  cmd_code,
    input  logic              cmd_ready,
    output logic [N_KEYS-1:0] pending,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int DMAX  = 2**DROP_W - 1;

    logic [N_KEYS-1:0] pend_q, pend_d;
    logic [CMD_W-1:0]  rr_q, rr_d, win;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [N_KEYS-1:0] gnt_mask, coal;
    logic [CNT_W-1:0]  count;
    logic              found, grant, full, empty, push, pop;
    int                idx, ncoal, tot;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_KEYS; k++) begin
            idx = (int'(rr_q) + k) % N_KEYS;
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                win   = CMD_W'(idx);
            end
        end
    end

    // Fullness is judged on the registered count, so a pop never frees a slot early.
    assign grant    = found && !full;
    assign gnt_mask = grant ? (N_KEYS'(1) << win) : '0;
    assign coal     = key_en & pend_q & ~gnt_mask;
    assign push     = grant && !flush;
    assign pop      = !empty && cmd_ready && !flush;

    always_comb begin
        ncoal = 0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (coal[i]) ncoal = ncoal + 1;
        end
        tot = int'(drop_q) + ncoal;
    end

    always_comb begin
        pend_d = (pend_q & ~gnt_mask) | key_en;
        rr_d   = rr_q;
        drop_d = (tot > DMAX) ? DROP_W'(DMAX) : DROP_W'(tot);
        if (grant) begin
            rr_d = (int'(win) == N_KEYS - 1) ? '0 : win + CMD_W'(1);
        end
        if (flush) begin
            pend_d = '0;
            rr_d   = '0;
            drop_d = drop_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pend_q <= '0;
            rr_q   <= '0;
            drop_q <= '0;
        end else begin
            pend_q <= pend_d;
            rr_q   <= rr_d;
            drop_q <= drop_d;
        end
    end

    cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (win),
        .pop_i   (pop),
        .data_o  (cmd_code),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign cmd_valid = (count != '0);
    assign pending   = pend_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_key_cmd_arbiter.sv
// Randomised and directed bench for key_cmd_arbiter against a
// queue-based behavioural model.
module tb_key_cmd_arbiter;
    import key_pkg::*;

    localparam int DEPTH = 4;
    localparam int DMAX  = 255;
    localparam int NK    = N_KEYS;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        flush = 1'b0;
    logic        cmd_ready = 1'b0;
    logic [5:0]  key_en = '0;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic [5:0]  pending;
    logic [7:0]  drop_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    logic [5:0] m_pend;
    int         m_q[$];
    int         m_rr;
    int         m_drop;
    int         got[$];

    key_cmd_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .DROP_W     (8)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .key_en    (key_en),
        .flush     (flush),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_ready (cmd_ready),
        .pending   (pending),
        .drop_cnt  (drop_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic model_step();
        int win;
        int nd;
        if (Rst) begin
            m_pend = '0;
            m_q.delete();
            m_rr = 0;
            m_drop = 0;
        end else if (flush) begin
            m_pend = '0;
            m_q.delete();
            m_rr = 0;
        end else begin
            win = -1;
            if (m_pend != 0 && m_q.size() < DEPTH) begin
                for (int k = 0; k < NK; k++) begin
                    if (win < 0 && m_pend[(m_rr + k) % NK])
                        win = (m_rr + k) % NK;
                end
            end
            nd = 0;
            for (int i = 0; i < NK; i++) begin
                if (key_en[i] && m_pend[i] && i != win) nd++;
            end
            m_drop = (m_drop + nd > DMAX) ? DMAX : m_drop + nd;
            if (m_q.size() != 0 && cmd_ready) void'(m_q.pop_front());
            if (win >= 0) begin
                m_q.push_back(win);
                m_pend[win] = 1'b0;
                m_rr = (win + 1) % NK;
            end
            m_pend = m_pend | key_en;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        flush = 1'b0;
        key_en = '0;
        cmd_ready = 1'b0;
        tick();
        Rst = 1'b0;
    endtask

    task automatic collect(input int n);
        got.delete();
        cmd_ready = 1'b1;
        for (int c = 0; c < 40 && got.size() < n; c++) begin
            if (cmd_valid) got.push_back(int'(cmd_code));
            tick();
        end
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        key_en = 6'b111111;
        flush = 1'b1;
        cmd_ready = 1'b1;
        repeat (3) tick();
        key_en = '0;
        flush = 1'b0;
        cmd_ready = 1'b0;
        Rst = 1'b0;
        tests_run++;
        if ({cmd_valid, cmd_code, pending, drop_cnt} !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset: valid=%b code=%0d pend=%b drop=%0d, want all 0",
                     cmd_valid, cmd_code, pending, drop_cnt);
        end
    endtask

    task automatic test_latency();
        key_en = 6'b000100;
        cmd_ready = 1'b1;
        tick();
        key_en = '0;
        tests_run++;
        if (pending !== 6'b000100 || cmd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat_t0: pend=%b valid=%b, want 000100 0",
                     pending, cmd_valid);
        end
        tick();
        tests_run++;
        if (cmd_valid !== 1'b1 || cmd_code !== 3'd2) begin
            tests_failed++;
            $display("FAIL lat_t1: valid=%b code=%0d, want 1 2",
                     cmd_valid, cmd_code);
        end
        tick();
        cmd_ready = 1'b0;
        tests_run++;
        if (cmd_valid !== 1'b0 || drop_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL lat_pop: valid=%b drop=%0d, want 0 0",
                     cmd_valid, drop_cnt);
        end
    endtask

    task automatic test_round_robin();
        int exp1[3] = '{0, 2, 5};
        int exp2[2] = '{0, 5};
        do_reset();
        key_en = 6'b100101;
        tick();
        key_en = '0;
        repeat (3) tick();
        tests_run++;
        if (pending !== 6'b0 || cmd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rr_pend: pend=%b valid=%b, want 000000 1",
                     pending, cmd_valid);
        end
        collect(3);
        tests_run++;
        if (got.size() != 3) begin
            tests_failed++;
            $display("FAIL rr_count: got %0d codes, want 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (got[i] != exp1[i]) begin
                    tests_failed++;
                    $display("FAIL rr_order[%0d]: got %0d want %0d",
                             i, got[i], exp1[i]);
                end
            end
        end
        key_en = 6'b100001;
        tick();
        key_en = '0;
        repeat (2) tick();
        collect(2);
        tests_run++;
        if (got.size() != 2 || got[0] != exp2[0] || got[1] != exp2[1]) begin
            tests_failed++;
            $display("FAIL rr_ptr_wrap: got %p want %p", got, exp2);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            key_en = 6'(1 << k);
            tick();
        end
        key_en = '0;
        tick();
        tests_run++;
        if (pending !== 6'b110000 || cmd_valid !== 1'b1 || cmd_code !== 3'd0) begin
            tests_failed++;
            $display("FAIL bp_full: pend=%b valid=%b code=%0d, want 110000 1 0",
                     pending, cmd_valid, cmd_code);
        end
        collect(6);
        tests_run++;
        if (got.size() != 6) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d codes, want 6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (got[i] != i) begin
                    tests_failed++;
                    $display("FAIL bp_order[%0d]: got %0d want %0d", i, got[i], i);
                end
            end
        end
    endtask

    task automatic test_coalesce();
        int ones;
        int keys[4] = '{0, 2, 3, 4};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            key_en = 6'(1 << keys[k]);
            tick();
        end
        key_en = '0;
        tick();
        key_en = 6'b000010;
        tick();
        repeat (3) tick();
        key_en = '0;
        tick();
        tests_run++;
        if (drop_cnt !== 8'd3 || pending !== 6'b000010) begin
            tests_failed++;
            $display("FAIL coal_drop: drop=%0d pend=%b, want 3 000010",
                     drop_cnt, pending);
        end
        collect(5);
        ones = 0;
        foreach (got[i]) if (got[i] == 1) ones++;
        tests_run++;
        if (got.size() != 5 || ones != 1) begin
            tests_failed++;
            $display("FAIL coal_deliver: codes=%0d ones=%0d, want 5 1",
                     got.size(), ones);
        end
        key_en = 6'b111111;
        repeat (70) tick();
        key_en = '0;
        tests_run++;
        if (drop_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL coal_sat: drop=%0d want 255", drop_cnt);
        end
        key_en = 6'b111111;
        tick();
        key_en = '0;
        tests_run++;
        if (drop_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL coal_sat_hold: drop=%0d want 255", drop_cnt);
        end
    endtask

    task automatic test_flush();
        int seen;
        do_reset();
        key_en = 6'b000011;
        tick();
        key_en = 6'b000010;
        tick();
        key_en = '0;
        tick();
        key_en = 6'b000011;
        tick();
        key_en = '0;
        tests_run++;
        if (pending !== 6'b000011 || drop_cnt !== 8'd1 || cmd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL fl_setup: pend=%b drop=%0d valid=%b, want 000011 1 1",
                     pending, drop_cnt, cmd_valid);
        end
        flush = 1'b1;
        key_en = 6'b010000;
        cmd_ready = 1'b1;
        tick();
        flush = 1'b0;
        key_en = '0;
        tests_run++;
        if (cmd_valid !== 1'b0 || pending !== 6'b0 || drop_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL fl_clear: valid=%b pend=%b drop=%0d, want 0 000000 1",
                     cmd_valid, pending, drop_cnt);
        end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (cmd_valid) seen++;
            tick();
        end
        cmd_ready = 1'b0;
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL fl_no_emit: %0d valid cycles after flush, want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int exp[3] = '{1, 2, 3};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            key_en = 6'(1 << k);
            tick();
        end
        key_en = '0;
        tick();
        key_en = 6'b001000;
        tick();
        key_en = '0;
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        tests_run++;
        if (cmd_valid !== 1'b1 || cmd_code !== 3'd1 || pending !== 6'b0) begin
            tests_failed++;
            $display("FAIL b2b_hi: valid=%b code=%0d pend=%b, want 1 1 000000",
                     cmd_valid, cmd_code, pending);
        end
        collect(3);
        tests_run++;
        if (got.size() != 3 || got[0] != exp[0] || got[1] != exp[1]
            || got[2] != exp[2] || cmd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_hi_order: got %p valid=%b, want %p 0",
                     got, cmd_valid, exp);
        end
        key_en = 6'b000001;
        tick();
        key_en = '0;
        tick();
        key_en = 6'b010000;
        tick();
        key_en = '0;
        cmd_ready = 1'b1;
        tick();
        tests_run++;
        if (cmd_valid !== 1'b1 || cmd_code !== 3'd4 || pending !== 6'b0) begin
            tests_failed++;
            $display("FAIL b2b_lo: valid=%b code=%0d pend=%b, want 1 4 000000",
                     cmd_valid, cmd_code, pending);
        end
        tick();
        cmd_ready = 1'b0;
        tests_run++;
        if (cmd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_lo_drain: valid=%b want 0", cmd_valid);
        end
        key_en = 6'b000111;
        tick();
        key_en = 6'b000011;
        repeat (2) tick();
        key_en = '0;
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        tests_run++;
        if ({cmd_valid, cmd_code, pending, drop_cnt} !== 18'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: valid=%b code=%0d pend=%b drop=%0d, want 0",
                     cmd_valid, cmd_code, pending, drop_cnt);
        end
    endtask

    task automatic test_random();
        int  ecode;
        logic ev;
        int  bad = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            key_en = 6'($urandom & $urandom);
            if (c % 150 < 75)
                cmd_ready = ($urandom_range(0, 3) == 0);
            else
                cmd_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 59) == 0);
            Rst = ($urandom_range(0, 249) == 0);
            tick();
            ev = (m_q.size() != 0);
            ecode = ev ? m_q[0] : 0;
            tests_run++;
            if (cmd_valid !== ev || cmd_code !== 3'(ecode) || pending !== m_pend
                || drop_cnt !== 8'(m_drop)) begin
                tests_failed++;
                if (bad < 10)
                    $display("FAIL rand[%0d]: v=%b c=%0d p=%b d=%0d, want %b %0d %b %0d",
                             c, cmd_valid, cmd_code, pending, drop_cnt,
                             ev, ecode, m_pend, m_drop);
                bad++;
            end
        end
        Rst = 1'b0;
        flush = 1'b0;
        key_en = '0;
        cmd_ready = 1'b0;
    endtask

    initial begin
        m_pend = '0;
        m_rr = 0;
        m_drop = 0;
        test_reset();
        test_latency();
        test_round_robin();
        test_backpressure();
        test_coalesce();
        test_flush();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
